e203_exu_nice_mq: RTL and testbench

Parametrised NICE dispatch unit for the E203 EXU with a configurable number of outstanding long-pipe coprocessor instructions. It sits between the EXU ALU dispatch path and the NICE coprocessor request/response channels. It forwards requests, reports long-pipe status to commit, and queues instruction tags in an ITAG FIFO of depth DEPTH. Unlike the previous generation, a full FIFO back-pressures dispatch, and occupancy and idle status are exported.

---
 rtl/e203_exu_nice_mq.sv | 100 ++++++++++
 tb/tb_e203_exu_nice_mq.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/e203_exu_nice_mq.sv
// rtl/e203_exu_nice_mq.sv - NICE dispatch unit with a DEPTH-entry ITAG FIFO for outstanding long-pipe instructions.
module e203_exu_nice_mq #(
    parameter int XLEN   = 32,
    parameter int ITAG_W = 2,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              nice_i_xs_off,
    input  logic              nice_i_valid,
    output logic              nice_i_ready,
    input  logic [XLEN-1:0]   nice_i_instr,
    input  logic [XLEN-1:0]   nice_i_rs1,
    input  logic [XLEN-1:0]   nice_i_rs2,
    input  logic [ITAG_W-1:0] nice_i_itag,
    output logic              nice_o_valid,
    input  logic              nice_o_ready,
    output logic              nice_o_longpipe,
    output logic              nice_o_itag_valid,
    input  logic              nice_o_itag_ready,
    output logic [ITAG_W-1:0] nice_o_itag,
    input  logic              nice_rsp_multicyc_valid,
    output logic              nice_rsp_multicyc_ready,
    output logic              nice_req_valid,
    input  logic              nice_req_ready,
    output logic [XLEN-1:0]   nice_req_instr,
    output logic [XLEN-1:0]   nice_req_rs1,
    output logic [XLEN-1:0]   nice_req_rs2,
    output logic [CNT_W-1:0]  nice_outstanding,
    output logic              nice_idle
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    logic [ITAG_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [CNT_W-1:0]  r_cnt;

    logic w_full;
    logic w_empty;
    logic w_ren;
    logic w_wen;
    logic w_space;
    logic w_req_rdy_pos;

    assign w_full  = (r_cnt == CNT_W'(DEPTH));
    assign w_empty = (r_cnt == '0);

    // Read side depends only on the response/writeback handshake, so the
    // dispatch ready path can use it without forming a combinational loop.
    assign w_ren         = nice_rsp_multicyc_valid & nice_o_itag_ready & ~w_empty;
    assign w_space       = ~w_full | w_ren;
    assign w_req_rdy_pos = nice_i_xs_off | (nice_req_ready & w_space);

    assign nice_i_ready    = w_req_rdy_pos & nice_o_ready;
    assign nice_o_valid    = nice_i_valid & w_req_rdy_pos;
    assign nice_req_valid  = ~nice_i_xs_off & nice_i_valid & nice_o_ready & w_space;
    assign nice_o_longpipe = ~nice_i_xs_off;
    assign nice_req_instr  = nice_i_instr;
    assign nice_req_rs1    = nice_i_rs1;
    assign nice_req_rs2    = nice_i_rs2;

    assign w_wen = nice_req_valid & nice_req_ready;

    assign nice_o_itag_valid       = ~w_empty & nice_rsp_multicyc_valid;
    assign nice_rsp_multicyc_ready = ~w_empty & nice_o_itag_ready;
    assign nice_o_itag             = r_mem[r_rptr];
    assign nice_outstanding        = r_cnt;
    assign nice_idle               = w_empty;

    always_ff @(posedge clk) begin
        if (w_wen) begin
            r_mem[r_wptr] <= nice_i_itag;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_wen) begin
                r_wptr <= (r_wptr == LAST_PTR) ? '0 : r_wptr + 1'b1;
            end
            if (w_ren) begin
                r_rptr <= (r_rptr == LAST_PTR) ? '0 : r_rptr + 1'b1;
            end
            case ({w_wen, w_ren})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_e203_exu_nice_mq.sv
// tb/tb_e203_exu_nice_mq.sv - scoreboard bench for e203_exu_nice_mq with DEPTH=4, ITAG_W=2.
module tb_e203_exu_nice_mq;

    localparam int XLEN   = 32;
    localparam int ITAG_W = 2;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              nice_i_xs_off = 1'b0;
    logic              nice_i_valid = 1'b0;
    logic              nice_i_ready;
    logic [XLEN-1:0]   nice_i_instr = '0;
    logic [XLEN-1:0]   nice_i_rs1 = '0;
    logic [XLEN-1:0]   nice_i_rs2 = '0;
    logic [ITAG_W-1:0] nice_i_itag = '0;
    logic              nice_o_valid;
    logic              nice_o_ready = 1'b0;
    logic              nice_o_longpipe;
    logic              nice_o_itag_valid;
    logic              nice_o_itag_ready = 1'b0;
    logic [ITAG_W-1:0] nice_o_itag;
    logic              nice_rsp_multicyc_valid = 1'b0;
    logic              nice_rsp_multicyc_ready;
    logic              nice_req_valid;
    logic              nice_req_ready = 1'b0;
    logic [XLEN-1:0]   nice_req_instr;
    logic [XLEN-1:0]   nice_req_rs1;
    logic [XLEN-1:0]   nice_req_rs2;
    logic [CNT_W-1:0]  nice_outstanding;
    logic              nice_idle;

    int n_checks = 0;
    int n_fail   = 0;
    logic [ITAG_W-1:0] exp_q[$];

    always #5 clk = ~clk;

    e203_exu_nice_mq #(.XLEN(XLEN), .ITAG_W(ITAG_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .nice_i_xs_off(nice_i_xs_off), .nice_i_valid(nice_i_valid), .nice_i_ready(nice_i_ready),
        .nice_i_instr(nice_i_instr), .nice_i_rs1(nice_i_rs1), .nice_i_rs2(nice_i_rs2),
        .nice_i_itag(nice_i_itag),
        .nice_o_valid(nice_o_valid), .nice_o_ready(nice_o_ready), .nice_o_longpipe(nice_o_longpipe),
        .nice_o_itag_valid(nice_o_itag_valid), .nice_o_itag_ready(nice_o_itag_ready),
        .nice_o_itag(nice_o_itag),
        .nice_rsp_multicyc_valid(nice_rsp_multicyc_valid),
        .nice_rsp_multicyc_ready(nice_rsp_multicyc_ready),
        .nice_req_valid(nice_req_valid), .nice_req_ready(nice_req_ready),
        .nice_req_instr(nice_req_instr), .nice_req_rs1(nice_req_rs1), .nice_req_rs2(nice_req_rs2),
        .nice_outstanding(nice_outstanding), .nice_idle(nice_idle)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic xs_off, input logic vld, input logic [ITAG_W-1:0] tag,
                         input logic rsp_vld);
        nice_i_xs_off           = xs_off;
        nice_i_valid            = vld;
        nice_i_itag             = tag;
        nice_rsp_multicyc_valid = rsp_vld;
        nice_o_ready            = 1'b1;
        nice_req_ready          = 1'b1;
        nice_o_itag_ready       = 1'b1;
    endtask

    // Monitor: every writeback handshake pops the oldest expected tag.
    always @(negedge clk) begin
        if (!rst && nice_o_itag_valid && nice_o_itag_ready) begin
            if (exp_q.size() == 0) begin
                chk("itag_unexpected", 64'(nice_o_itag_valid), 64'd0);
            end else begin
                chk("itag_order", 64'(nice_o_itag), 64'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        tick(); tick();
        rst = 1'b0;
        drive(1'b0, 1'b0, 2'd0, 1'b1);
        @(negedge clk);
        chk("rst_outstanding", 64'(nice_outstanding), 64'd0);
        chk("rst_idle", 64'(nice_idle), 64'd1);
        chk("rst_itag_valid", 64'(nice_o_itag_valid), 64'd0);
        chk("rst_rsp_ready", 64'(nice_rsp_multicyc_ready), 64'd0);
        tick();

        // xs_off: commit only, no request, no FIFO write
        drive(1'b1, 1'b1, 2'd2, 1'b0);
        @(negedge clk);
        chk("xsoff_req_valid", 64'(nice_req_valid), 64'd0);
        chk("xsoff_i_ready", 64'(nice_i_ready), 64'd1);
        chk("xsoff_o_valid", 64'(nice_o_valid), 64'd1);
        chk("xsoff_longpipe", 64'(nice_o_longpipe), 64'd0);
        tick();
        chk("xsoff_no_write", 64'(nice_outstanding), 64'd0);

        drive(1'b0, 1'b0, 2'd0, 1'b1);
        @(negedge clk);
        chk("empty_rsp_ready", 64'(nice_rsp_multicyc_ready), 64'd0);
        chk("empty_itag_valid", 64'(nice_o_itag_valid), 64'd0);
        tick();
        chk("empty_cnt", 64'(nice_outstanding), 64'd0);

        for (int t = 0; t < 4; t++) begin
            drive(1'b0, 1'b1, 2'(t), 1'b0);
            nice_i_instr = 32'h0000_007B + 32'(t << 12);
            nice_i_rs1   = 32'hA5A5_0000 + 32'(t);
            nice_i_rs2   = 32'h5A5A_FFF0 - 32'(t);
            exp_q.push_back(2'(t));
            @(negedge clk);
            chk("fill_req_valid", 64'(nice_req_valid), 64'd1);
            chk("fill_i_ready", 64'(nice_i_ready), 64'd1);
            if (t == 0) begin
                chk("pass_o_valid", 64'(nice_o_valid), 64'd1);
                chk("pass_longpipe", 64'(nice_o_longpipe), 64'd1);
                chk("pass_instr", 64'(nice_req_instr), 64'h0000_007B);
                chk("pass_rs1", 64'(nice_req_rs1), 64'hA5A5_0000);
                chk("pass_rs2", 64'(nice_req_rs2), 64'h5A5A_FFF0);
            end
            tick();
        end
        chk("full_cnt", 64'(nice_outstanding), 64'd4);
        chk("full_idle", 64'(nice_idle), 64'd0);

        drive(1'b0, 1'b1, 2'd3, 1'b0);
        @(negedge clk);
        chk("bp_req_valid", 64'(nice_req_valid), 64'd0);
        chk("bp_i_ready", 64'(nice_i_ready), 64'd0);
        chk("bp_o_valid", 64'(nice_o_valid), 64'd0);
        tick();
        chk("bp_cnt", 64'(nice_outstanding), 64'd4);

        drive(1'b0, 1'b0, 2'd0, 1'b1);
        tick(); tick(); tick();
        chk("drain3_cnt", 64'(nice_outstanding), 64'd1);
        chk("drain3_idle", 64'(nice_idle), 64'd0);
        tick();
        chk("drain4_cnt", 64'(nice_outstanding), 64'd0);
        chk("drain4_idle", 64'(nice_idle), 64'd1);

        for (int t = 0; t < 4; t++) begin
            drive(1'b0, 1'b1, 2'(t), 1'b0);
            exp_q.push_back(2'(t));
            tick();
        end
        // Full with a concurrent read: write is allowed, occupancy holds at DEPTH
        drive(1'b0, 1'b1, 2'd2, 1'b1);
        exp_q.push_back(2'd2);
        @(negedge clk);
        chk("fullrw_req_valid", 64'(nice_req_valid), 64'd1);
        chk("fullrw_i_ready", 64'(nice_i_ready), 64'd1);
        chk("fullrw_rsp_ready", 64'(nice_rsp_multicyc_ready), 64'd1);
        tick();
        chk("fullrw_cnt", 64'(nice_outstanding), 64'd4);
        drive(1'b0, 1'b0, 2'd0, 1'b1);
        for (int i = 0; i < 4; i++) tick();
        chk("fullrw_drained", 64'(nice_outstanding), 64'd0);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        // Empty with concurrent read and write: write only
        drive(1'b0, 1'b1, 2'd1, 1'b1);
        exp_q.push_back(2'd1);
        @(negedge clk);
        chk("emptyrw_rsp_ready", 64'(nice_rsp_multicyc_ready), 64'd0);
        chk("emptyrw_itag_valid", 64'(nice_o_itag_valid), 64'd0);
        chk("emptyrw_req_valid", 64'(nice_req_valid), 64'd1);
        tick();
        chk("emptyrw_cnt", 64'(nice_outstanding), 64'd1);

        for (int t = 2; t < 4; t++) begin
            drive(1'b0, 1'b1, 2'(t), 1'b0);
            exp_q.push_back(2'(t));
            tick();
        end
        chk("pre_rst_cnt", 64'(nice_outstanding), 64'd3);

        // Asynchronous reset between edges discards queued tags
        drive(1'b0, 1'b0, 2'd0, 1'b1);
        rst = 1'b1;
        #1;
        chk("async_rst_cnt", 64'(nice_outstanding), 64'd0);
        chk("async_rst_idle", 64'(nice_idle), 64'd1);
        chk("async_rst_itag_valid", 64'(nice_o_itag_valid), 64'd0);
        exp_q.delete();
        #1;
        rst = 1'b0;
        tick();
        chk("post_rst_cnt", 64'(nice_outstanding), 64'd0);
        chk("post_rst_itag_valid", 64'(nice_o_itag_valid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
